// File: rtl/binary_count_gen_if.sv
// Valid/ready bus carrying the binary count word to the binary_to_gray stage.
// The optional gray copy is present when BCG_GRAY_OUT_EN is defined.
interface binary_count_gen_if #(
    parameter int WIDTH = 4
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] binary;
    logic             tc;
`ifdef BCG_GRAY_OUT_EN
    logic [WIDTH-1:0] gray;
`endif

    modport master (
        input  out_ready,
        output out_valid,
        output binary,
`ifdef BCG_GRAY_OUT_EN
        output gray,
`endif
        output tc
    );

    modport slave (
        output out_ready,
        input  out_valid,
        input  binary,
`ifdef BCG_GRAY_OUT_EN
        input  gray,
`endif
        input  tc
    );
endinterface

// File: rtl/binary_count_gen.sv
// Up/down wrap-around counter presenting each count as a valid/ready beat.
// Define BCG_GRAY_OUT_EN to add a registered Gray-coded copy of the count.
module binary_count_gen #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = (1 << WIDTH) - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               up_dn,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    binary_count_gen_if.master ob
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] binary_reg, binary_next;
    logic             tc_reg, tc_next;
    logic             valid_next;
    logic             hs;
    logic             wrap;
    logic [WIDTH-1:0] advanced;
    logic [WIDTH-1:0] load_clamped;

    assign hs           = (state_reg == RUN) && ob.out_ready;
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // Wrap is decided against MAX_VAL, so a non-power-of-two MAX_COUNT never overshoots.
    always_comb begin
        wrap     = 1'b0;
        advanced = binary_reg;
        if (up_dn) begin
            wrap     = (binary_reg == MAX_VAL);
            advanced = wrap ? '0 : binary_reg + WIDTH'(1);
        end else begin
            wrap     = (binary_reg == '0);
            advanced = wrap ? MAX_VAL : binary_reg - WIDTH'(1);
        end
    end

    always_comb begin
        state_next  = state_reg;
        binary_next = binary_reg;
        tc_next     = 1'b0;
        valid_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    binary_next = load_clamped;
                end
                if (en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                valid_next = 1'b1;
                // Without a handshake the word is frozen: en and load are ignored.
                if (hs) begin
                    if (load) begin
                        binary_next = load_clamped;
                    end else begin
                        binary_next = advanced;
                        tc_next     = wrap;
                    end
                    if (!en) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            binary_reg <= '0;
            tc_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            binary_reg <= binary_next;
            tc_reg     <= tc_next;
        end
    end

    assign ob.out_valid = valid_next;
    assign ob.binary    = binary_reg;
    assign ob.tc        = tc_reg;

`ifdef BCG_GRAY_OUT_EN
    logic [WIDTH-1:0] gray_reg;
    logic [WIDTH-1:0] gray_next;

    // Encoded from binary_next so the gray register lands in the same cycle as binary.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gray
        if (gi == WIDTH - 1) begin : g_msb
            assign gray_next[gi] = binary_next[gi];
        end else begin : g_bit
            assign gray_next[gi] = binary_next[gi] ^ binary_next[gi+1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gray_reg <= '0;
        end else begin
            gray_reg <= gray_next;
        end
    end

    assign ob.gray = gray_reg;
`endif

endmodule

// File: tb/tb_binary_count_gen.sv
// Scoreboard bench: two counters (MAX_COUNT 15 and 9) share one random stimulus stream
// and are checked against an arithmetic reference model per lane.
module tb_binary_count_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam int MAXC = (gi == 0) ? 15 : 9;

        binary_count_gen_if #(.WIDTH(4)) bus ();
        assign bus.out_ready = out_ready;

        binary_count_gen #(.WIDTH(4), .MAX_COUNT(MAXC)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .up_dn    (up_dn),
            .load     (load),
            .load_val (load_val),
            .ob       (bus)
        );

        // Reference model: a count in 0..MAXC plus an "offering a word" flag.
        int m_count  = 0;
        bit m_active = 1'b0;
        bit m_tc     = 1'b0;
        bit vq[$];
        bit tq[$];
        int beat_q[$];

        always @(posedge clk) begin : model
            bit m_hs;
            if (!rst_n) begin
                m_count  = 0;
                m_active = 1'b0;
                m_tc     = 1'b0;
            end else begin
                m_hs = m_active && out_ready;
                m_tc = 1'b0;
                if (!m_active || m_hs) begin
                    if (load) begin
                        m_count = (int'(load_val) > MAXC) ? MAXC : int'(load_val);
                    end else if (m_active) begin
                        if (up_dn) begin
                            m_count = (m_count + 1) % (MAXC + 1);
                            m_tc    = (m_count == 0);
                        end else begin
                            m_count = (m_count + MAXC) % (MAXC + 1);
                            m_tc    = (m_count == MAXC);
                        end
                    end
                    m_active = en;
                    if (m_active) beat_q.push_back(m_count);
                end
            end
            vq.push_back(m_active);
            tq.push_back(m_tc);
        end

        bit       pv = 1'b0;
        bit       pr = 1'b0;
        bit [3:0] pb = '0;

        always @(negedge clk) begin : monitor
            bit ev, et;
            int eb;
            if (vq.size() != 0) begin
                ev = vq.pop_front();
                et = tq.pop_front();
                chk($sformatf("lane%0d out_valid", gi), int'(bus.out_valid), int'(ev));
                chk($sformatf("lane%0d tc", gi), int'(bus.tc), int'(et));
`ifdef BCG_GRAY_OUT_EN
                chk($sformatf("lane%0d gray", gi), int'(bus.gray),
                    int'(bus.binary ^ (bus.binary >> 1)));
`endif
                if (pv && !pr && rst_n) begin
                    chk($sformatf("lane%0d stable binary", gi), int'(bus.binary), int'(pb));
                end
                if (bus.out_valid && (!pv || pr)) begin
                    if (beat_q.size() == 0) begin
                        chk($sformatf("lane%0d unexpected beat", gi), int'(bus.binary), -1);
                    end else begin
                        eb = beat_q.pop_front();
                        chk($sformatf("lane%0d beat binary", gi), int'(bus.binary), eb);
                        $display("lane%0d beat binary=%0d tc=%0d", gi, bus.binary, bus.tc);
                    end
                end
            end
            pv = bus.out_valid;
            pr = out_ready;
            pb = bus.binary;
        end
    end

    task automatic drive(input bit e, input bit u, input bit l, input int lv, input bit r);
        en        = e;
        up_dn     = u;
        load      = l;
        load_val  = 4'(lv);
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        up_dn     = 1'b1;
        load      = 1'b0;
        load_val  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Free-running up count through the wrap.
        repeat (18) drive(1, 1, 0, 0, 1);

        // Backpressure on word 6.
        drive(1, 1, 1, 6, 1);
        repeat (5) drive(1, 1, 0, 0, 0);
        repeat (3) drive(1, 1, 0, 0, 1);

        // Drop to IDLE, load 1 there, then count down through zero.
        drive(0, 1, 0, 0, 1);
        drive(0, 1, 0, 0, 1);
        drive(1, 0, 1, 1, 1);
        repeat (5) drive(1, 0, 0, 0, 1);

        // Load ignored without handshake, honoured with one; then clamp.
        repeat (2) drive(1, 0, 1, 9, 0);
        drive(1, 1, 1, 9, 1);
        repeat (2) drive(1, 1, 0, 0, 1);
        drive(1, 1, 1, 12, 1);
        repeat (2) drive(1, 1, 0, 0, 1);

        // Load together with hs and en=0.
        drive(0, 1, 1, 3, 1);
        repeat (2) drive(1, 1, 0, 0, 1);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                drive(1, 1, 0, 0, 1);
                drive(1, 1, 0, 0, 1);
                rst_n = 1'b1;
            end
            drive(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0));
        end

        repeat (4) drive(0, 1, 0, 0, 1);
        @(negedge clk);
        #2;
        chk("lane0 beats left over", g_lane[0].beat_q.size(), 0);
        chk("lane1 beats left over", g_lane[1].beat_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
